// File: rtl/conv_enc_tx_pkg.sv
// Shared Viterbi datapath definitions: default code constants, encoder state
// type and the parity helper used by both encoder and decoder tables.
package viterbi_pkg;

  localparam int unsigned K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // Operands are zero-extended to 32 bits so one function serves any K <= 32.
  function automatic logic parity(input logic [31:0] poly, input logic [31:0] window);
    return ^(poly & window);
  endfunction

endpackage

// File: rtl/conv_enc_tx_if.sv
// Stream interface of the convolutional encoder: bit input, pair output, status.
interface conv_enc_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_pair;
  logic       out_last;
  logic       busy;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_pair, out_last, busy
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_pair, out_last, busy
  );
endinterface

// File: rtl/conv_enc_tx_pair_gen.sv
// Combinational map from encoder window {b, sr} to the rate-1/2 code pair.
module enc_pair_gen
  import viterbi_pkg::*;
#(
  parameter int unsigned    K  = viterbi_pkg::K,
  parameter logic [K-1:0]   G0 = viterbi_pkg::G0,
  parameter logic [K-1:0]   G1 = viterbi_pkg::G1
) (
  input  logic [K-1:0] window,
  output logic [1:0]   pair
);

  always_comb begin
    pair    = '0;
    pair[1] = parity(32'(G0), 32'(window));
    pair[0] = parity(32'(G1), 32'(window));
  end

endmodule

// File: rtl/conv_enc_tx.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination and a
// registered, backpressure-aware output stage.
module conv_enc_tx
  import viterbi_pkg::*;
#(
  parameter int unsigned  K  = viterbi_pkg::K,
  parameter logic [K-1:0] G0 = viterbi_pkg::G0,
  parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_enc_tx_if.slave bus
);

  localparam int unsigned     TW        = $clog2(K) + 1;
  localparam logic [TW-1:0]   TAIL_INIT = TW'(K - 1);

  enc_state_t     state, state_nx;
  logic [K-2:0]   sr, sr_nx;
  logic [TW-1:0]  tail_cnt, tail_cnt_nx;
  logic [1:0]     pair_q, pair_nx, pair_enc;
  logic           valid_q, valid_nx;
  logic           last_q, last_nx;
  logic           slot_free, in_rdy, accept, tail_step, tail_done, b;
  logic [K-1:0]   window;

  assign slot_free = !valid_q || bus.out_ready;
  assign in_rdy    = slot_free && (state != TAIL);
  assign accept    = bus.in_valid && in_rdy;
  assign tail_step = (state == TAIL) && slot_free;
  assign tail_done = (tail_cnt == TW'(1));
  assign b         = (state == TAIL) ? 1'b0 : bus.in_bit;
  assign window    = {b, sr};

  enc_pair_gen #(.K(K), .G0(G0), .G1(G1)) u_pair_gen (
    .window (window),
    .pair   (pair_enc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      tail_cnt <= TAIL_INIT;
      pair_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      tail_cnt <= tail_cnt_nx;
      pair_q   <= pair_nx;
      valid_q  <= valid_nx;
      last_q   <= last_nx;
    end
  end

  // Input acceptance and tail steps are mutually exclusive (in_ready is low in
  // TAIL), so one priority chain covers every update of the encoder state.
  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    tail_cnt_nx = tail_cnt;
    pair_nx     = pair_q;
    valid_nx    = valid_q;
    last_nx     = last_q;
    if (accept) begin
      sr_nx    = window[K-1:1];
      pair_nx  = pair_enc;
      valid_nx = 1'b1;
      last_nx  = 1'b0;
      state_nx = bus.in_last ? TAIL : DATA;
    end else if (tail_step) begin
      sr_nx    = window[K-1:1];
      pair_nx  = pair_enc;
      valid_nx = 1'b1;
      last_nx  = tail_done;
      if (tail_done) begin
        state_nx    = IDLE;
        tail_cnt_nx = TAIL_INIT;
      end else begin
        tail_cnt_nx = tail_cnt - TW'(1);
      end
    end else if (bus.out_ready) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_pair  = pair_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state != IDLE) || valid_q;

endmodule

// File: tb/tb_conv_enc_tx.sv
// Self-checking bench for conv_enc_tx: convolution model plus directed frames.
module tb_conv_enc_tx;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  conv_enc_tx_if bus();

  conv_enc_tx #(.K(3), .G0(3'b111), .G1(3'b101)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_count = 0;
  int          stall_mode = 0;
  int unsigned rdy_cyc = 0;
  logic [2:0]  expq[$];
  logic [2:0]  mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Code pair i is the generator-weighted XOR of input bits u[i-j], j=0..K-1,
  // with bits outside the frame (history before, tail after) taken as 0.
  function automatic void model_frame(input logic [15:0] u, input int n, input bit with_tail);
    int ki;
    int total;
    ki    = int'(K);
    total = with_tail ? n + ki - 1 : n;
    mq.delete();
    for (int i = 0; i < total; i++) begin
      logic p1, p0, v;
      p1 = 1'b0;
      p0 = 1'b0;
      for (int j = 0; j < ki; j++) begin
        v  = (i - j >= 0 && i - j < n) ? u[i - j] : 1'b0;
        p1 = p1 ^ (G0[ki - 1 - j] & v);
        p0 = p0 ^ (G1[ki - 1 - j] & v);
      end
      mq.push_back({(with_tail && i == total - 1), p1, p0});
    end
  endfunction

  function automatic logic [31:0] pack_mq();
    logic [31:0] v;
    v = '0;
    foreach (mq[i]) v = (v << 3) | 32'(mq[i]);
    return v;
  endfunction

  always @(negedge clk) begin
    rdy_cyc++;
    if (stall_mode == 0) bus.out_ready = 1'b1;
    else bus.out_ready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
  end

  // Output checker: every transfer against the model queue, every stall for hold.
  logic       stall_prev = 1'b0;
  logic [2:0] held = '0;
  always @(negedge clk) begin
    logic [2:0] e;
    #3;
    if (bus.out_valid && bus.out_ready) begin
      hs_count++;
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pair: got 0x%0h expected none", {bus.out_last, bus.out_pair});
      end else begin
        e = expq.pop_front();
        check("pair_last", 32'({bus.out_last, bus.out_pair}), 32'(e));
      end
    end
    if (stall_prev && rst_n)
      check("stall_hold", 32'({bus.out_valid, bus.out_last, bus.out_pair}), 32'({1'b1, held}));
    stall_prev = rst_n && bus.out_valid && !bus.out_ready;
    held       = {bus.out_last, bus.out_pair};
  end

  task automatic send_bit(input logic bt, input logic last);
    int  waitc;
    bit  done;
    waitc = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = bt;
      bus.in_last  = last;
      #1;
      if (bus.in_ready) done = 1'b1;
      else if (++waitc > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        done = 1'b1;
      end
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] u, input int n);
    model_frame(u, n, 1'b1);
    foreach (mq[i]) expq.push_back(mq[i]);
    for (int i = 0; i < n; i++) send_bit(u[i], (i == n - 1));
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (expq.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    if (expq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
      expq.delete();
    end
  endtask

  initial begin
    int base;
    int lows;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pair", 32'(bus.out_pair), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Model pinned against hand-computed sequences {last,p1,p0}.
    model_frame(16'b1101, 4, 1'b1);
    check("model_1011", pack_mq(), 32'({3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111}));
    model_frame(16'b1, 1, 1'b1);
    check("model_1", pack_mq(), 32'({3'b011, 3'b010, 3'b111}));
    model_frame(16'b10, 2, 1'b1);
    check("model_01", pack_mq(), 32'({3'b000, 3'b011, 3'b010, 3'b111}));
    model_frame(16'b0, 8, 1'b1);
    check("model_zero8", pack_mq(), 32'd4);
    check("model_zero8_len", 32'(mq.size()), 32'd10);

    // Frame 1,0,1,1 at full rate.
    base = hs_count;
    send_frame(16'b1101, 4);
    idle_in();
    wait_drain();
    check("frame1011_count", 32'(hs_count - base), 32'd6);
    #1;
    check("frame1011_busy_after", 32'(bus.busy), 32'd0);

    // Single-bit frame: two tail cycles with in_ready low.
    base = hs_count;
    send_frame(16'b1, 1);
    lows = 0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        if (bus.in_ready) seen = 1'b1;
        else lows++;
      end
    end
    check("tail_ready_low_cycles", 32'(lows), 32'd2);
    wait_drain();
    check("frame1_count", 32'(hs_count - base), 32'd3);

    // Same 4-bit frame under a 1,0,0,1 out_ready pattern.
    @(negedge clk);
    stall_mode = 1;
    rdy_cyc = 0;
    base = hs_count;
    send_frame(16'b1101, 4);
    idle_in();
    wait_drain();
    check("stall_frame_count", 32'(hs_count - base), 32'd6);
    @(negedge clk);
    stall_mode = 0;
    repeat (3) @(posedge clk);

    // Back-to-back frames; the second starts from a cleared register.
    base = hs_count;
    send_frame(16'b1101, 4);
    send_frame(16'b10, 2);
    idle_in();
    wait_drain();
    check("b2b_count", 32'(hs_count - base), 32'd10);

    // Reset after the second bit discards the partial frame.
    model_frame(16'b01, 2, 1'b0);
    foreach (mq[i]) expq.push_back(mq[i]);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    #4;
    check("midreset_pending", 32'(expq.size()), 32'd0);
    base = hs_count;
    send_frame(16'b1, 1);
    idle_in();
    wait_drain();
    check("post_reset_count", 32'(hs_count - base), 32'd3);

    // All-zero 8-bit frame.
    base = hs_count;
    send_frame(16'b0, 8);
    idle_in();
    wait_drain();
    check("zero8_count", 32'(hs_count - base), 32'd10);

    repeat (4) @(posedge clk);
    #1;
    check("final_idle_valid", 32'(bus.out_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
